// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: cathode code table (dp off, active-low, a in bit 7)
// and the reverse lookup used by the scan decoder.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [7:0] SEG_CODES [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h05, 8'hC1, 8'h63, 8'h85, 8'h21, 8'h71
    };

    // Returns {hit, nibble}; only segments a..g take part, dp is ignored.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (!r[4] && (SEG_CODES[i][7:1] == seg)) begin
                r = {1'b1, 4'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_stable_det.sv
// Sample register plus stability counter; emits a single commit strobe once the
// captured {an, cathode} word has been steady for STABLE_CYCLES samples.
//
//   state | meaning
//   TRACK | cnt < STABLE_CYCLES, sample still settling, no commit
//   HELD  | cnt == STABLE_CYCLES, one commit on entry, then idle until change
module seg_stable_det
    import seg_pkg::*;
#(
    parameter int W             = 12,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sample_in,
    output logic [W-1:0] held,
    output logic         commit
);

    localparam logic [0:0] ST_TRACK = 1'b0;
    localparam logic [0:0] ST_HELD  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYCLES);

    logic [W-1:0]     s_q;
    logic [CNT_W-1:0] cnt;
    logic             done;
    logic [0:0]       st;

    always_comb begin
        st     = (cnt == CNT_SAT) ? ST_HELD : ST_TRACK;
        commit = (st == ST_HELD) && !done;
        held   = s_q;
    end

    // done is set even when the commit is later discarded by clear, so a
    // saturated window never retries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q  <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            s_q <= sample_in;
            if (sample_in != s_q) begin
                cnt  <= CNT_W'(1);
                done <= 1'b0;
            end else begin
                if (cnt != CNT_SAT) begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (commit) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers per-position hex digits from a multiplexed active-low 7-segment drive,
// committing only stable anode/cathode combinations and flagging illegal ones.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_DIGITS-1:0]         an,
    input  logic [0:7]                    cathode,
    input  logic                          clear,
    output logic [4*NUM_DIGITS-1:0]       digits,
    output logic [NUM_DIGITS-1:0]         digit_valid,
    output logic [NUM_DIGITS-1:0]         dp,
    output logic                          update,
    output logic [$clog2(NUM_DIGITS)-1:0] upd_idx,
    output logic                          err,
    output logic                          err_sticky
);

    localparam int W     = NUM_DIGITS + 8;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [W-1:0]          held;
    logic                  commit;
    logic [NUM_DIGITS-1:0] an_h;
    logic [7:0]            cat_h;
    logic [NUM_DIGITS-1:0] an_z;
    int                    nlow;
    logic [IDX_W-1:0]      idx;
    logic [4:0]            dec;
    logic                  legal;
    logic                  illegal;

    seg_stable_det #(
        .W             (W),
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_stable (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_in ({an, cathode}),
        .held      (held),
        .commit    (commit)
    );

    // cat_h[7:1] are segments a..g, cat_h[0] is the decimal point.
    always_comb begin
        an_h  = held[W-1:8];
        cat_h = held[7:0];
        an_z  = ~an_h;
        nlow  = $countones(an_z);
        idx   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_z[i]) begin
                idx = IDX_W'(i);
            end
        end
        dec     = seg_decode(cat_h[7:1]);
        legal   = (nlow == 1) && dec[4];
        illegal = (nlow > 1) || ((nlow == 1) && !dec[4]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits      <= '0;
            digit_valid <= '0;
            dp          <= '0;
            update      <= 1'b0;
            upd_idx     <= '0;
            err         <= 1'b0;
            err_sticky  <= 1'b0;
        end else begin
            update <= 1'b0;
            err    <= 1'b0;
            if (clear) begin
                digit_valid <= '0;
                err_sticky  <= 1'b0;
            end else if (commit) begin
                if (legal) begin
                    digits[4*idx +: 4] <= dec[3:0];
                    dp[idx]            <= ~cat_h[0];
                    digit_valid[idx]   <= 1'b1;
                    update             <= 1'b1;
                    upd_idx            <= idx;
                end else if (illegal) begin
                    err        <= 1'b1;
                    err_sticky <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: a timestamp-based model checked every cycle,
// plus hand-computed expectations for latency and decoded values.
module tb_seg_scan_decoder;

    localparam int ND = 4;
    localparam int S  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [ND-1:0] an_i = 4'hF;
    logic [7:0]    cat_i = 8'hFF;
    logic          clear = 1'b0;

    logic [4*ND-1:0] digits;
    logic [ND-1:0]   digit_valid;
    logic [ND-1:0]   dp;
    logic            update;
    logic [1:0]      upd_idx;
    logic            err;
    logic            err_sticky;

    int n_checks = 0;
    int n_fail   = 0;
    int upd_count = 0;
    int err_count = 0;

    seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an_i),
        .cathode     (cat_i),
        .clear       (clear),
        .digits      (digits),
        .digit_valid (digit_valid),
        .dp          (dp),
        .update      (update),
        .upd_idx     (upd_idx),
        .err         (err),
        .err_sticky  (err_sticky)
    );

    always #5 clk = ~clk;

    logic [7:0] tbl [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h05, 8'hC1, 8'h63, 8'h85, 8'h21, 8'h71
    };

    // Model: a value captured at edge t commits at edge t+S if unchanged meanwhile.
    logic [4*ND-1:0] m_digits = '0;
    logic [ND-1:0]   m_valid = '0;
    logic [ND-1:0]   m_dp = '0;
    logic            m_update = 1'b0;
    logic [1:0]      m_idx = '0;
    logic            m_err = 1'b0;
    logic            m_sticky = 1'b0;
    logic [ND+7:0]   cur = '0;
    int              cyc = 0;
    int              run_start = 1;

    task automatic model_commit(input logic [ND+7:0] v);
        logic [ND-1:0] a;
        logic [7:0]    c;
        int zeros, k, hit;
        a = v[ND+7:8];
        c = v[7:0];
        zeros = 0;
        k = 0;
        hit = -1;
        for (int i = 0; i < ND; i++) begin
            if (!a[i]) begin
                zeros++;
                k = i;
            end
        end
        for (int i = 0; i < 16; i++) begin
            if ((c | 8'h01) == tbl[i]) hit = i;
        end
        if (zeros == 0) begin
        end else if (zeros > 1 || hit < 0) begin
            m_err = 1'b1;
            m_sticky = 1'b1;
        end else begin
            m_digits[k*4 +: 4] = 4'(hit);
            m_dp[k]    = ~c[0];
            m_valid[k] = 1'b1;
            m_update   = 1'b1;
            m_idx      = 2'(k);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_digits = '0; m_valid = '0; m_dp = '0; m_update = 1'b0;
            m_idx = '0; m_err = 1'b0; m_sticky = 1'b0;
            cur = '0;
            run_start = cyc + 1;
        end else begin
            cyc++;
            m_update = 1'b0;
            m_err = 1'b0;
            if (clear) begin
                m_valid = '0;
                m_sticky = 1'b0;
            end else if (cyc == run_start + S) begin
                model_commit(cur);
            end
            if ({an_i, cat_i} != cur) begin
                cur = {an_i, cat_i};
                run_start = cyc;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("digits", 32'(digits), 32'(m_digits));
        chk("digit_valid", 32'(digit_valid), 32'(m_valid));
        chk("dp", 32'(dp), 32'(m_dp));
        chk("update", 32'(update), 32'(m_update));
        chk("err", 32'(err), 32'(m_err));
        chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
        chk("update_err_excl", 32'(update & err), 32'd0);
        if (m_update) chk("upd_idx", 32'(upd_idx), 32'(m_idx));
    end

    always @(posedge clk) begin
        #1;
        if (update) upd_count++;
        if (err) err_count++;
    end

    task automatic apply(input logic [ND-1:0] a, input logic [7:0] c, input int n);
        an_i = a;
        cat_i = c;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_update(input logic [ND-1:0] a, input logic [7:0] c,
                               input int max, output int lat);
        an_i = a;
        cat_i = c;
        lat = 0;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (update) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) $display("FAIL wait_update: no update within %0d cycles", max);
    endtask

    int lat;
    int u0;
    int e0;

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_digits", 32'(digits), 32'd0);
        chk("reset_valid", 32'(digit_valid), 32'd0);
        repeat (6) @(negedge clk);

        // Digit 2 on slot 0: commit STABLE_CYCLES edges after first capture.
        wait_update(4'b1110, 8'h25, 10, lat);
        chk("t1_latency", 32'(lat), 32'd5);
        chk("t1_idx", 32'(upd_idx), 32'd0);
        chk("t1_digit", 32'(digits[3:0]), 32'h2);
        chk("t1_valid", 32'(digit_valid), 32'h1);
        chk("t1_dp", 32'(dp), 32'h0);
        u0 = upd_count;
        apply(4'b1110, 8'h25, 10);
        chk("t1_no_repeat", 32'(upd_count - u0), 32'd0);

        // b with dp lit on slot 2, then a restarted window.
        wait_update(4'b1011, 8'hC0, 10, lat);
        chk("t2_latency", 32'(lat), 32'd5);
        chk("t2_digit", 32'(digits[11:8]), 32'hB);
        chk("t2_dp", 32'(dp[2]), 32'd1);
        chk("t2_idx", 32'(upd_idx), 32'd2);
        u0 = upd_count;
        apply(4'b1011, 8'h09, 2);
        apply(4'b1011, 8'h03, 4);
        chk("t2_no_early", 32'(upd_count - u0), 32'd0);
        wait_update(4'b1011, 8'h03, 4, lat);
        chk("t2_restart_latency", 32'(lat), 32'd1);
        chk("t2_digit0", 32'(digits[11:8]), 32'h0);

        // Full scan with blank gaps.
        e0 = err_count;
        for (int k = 0; k < ND; k++) begin
            apply(4'hF, 8'hFF, 2);
            apply(~(4'b1 << k), tbl[k+1], 6);
        end
        chk("t3_digits", 32'(digits), 32'h4321);
        chk("t3_valid", 32'(digit_valid), 32'hF);
        chk("t3_no_err", 32'(err_count - e0), 32'd0);
        chk("t3_sticky", 32'(err_sticky), 32'd0);

        // Illegal patterns.
        apply(4'b1101, 8'hFE, 6);
        chk("t4_err", 32'(err_count - e0), 32'd1);
        chk("t4_sticky", 32'(err_sticky), 32'd1);
        chk("t4_digit", 32'(digits[7:4]), 32'h2);
        apply(4'b1100, 8'h03, 6);
        chk("t4_multi_an", 32'(err_count - e0), 32'd2);

        // clear coinciding with the commit edge drops the commit for good.
        u0 = upd_count;
        apply(4'b1110, 8'h99, 4);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("t5_no_update", 32'(upd_count - u0), 32'd0);
        chk("t5_valid", 32'(digit_valid), 32'h0);
        chk("t5_sticky", 32'(err_sticky), 32'd0);
        chk("t5_digits", 32'(digits), 32'h4321);
        apply(4'b1110, 8'h99, 6);
        chk("t5_no_retry", 32'(upd_count - u0), 32'd0);

        // Asynchronous reset in the middle of a window.
        apply(4'b0111, 8'h49, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_digits", 32'(digits), 32'd0);
        chk("t6_flags", 32'({digit_valid, dp, update, err, err_sticky, upd_idx}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_update(4'b0111, 8'h49, 10, lat);
        chk("t6_latency", 32'(lat), 32'd5);
        chk("t6_digits_after", 32'(digits), 32'h5000);
        chk("t6_valid", 32'(digit_valid), 32'h8);

        apply(4'hF, 8'hFF, 3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Reads the multiplexed 7-segment drive (active-low anodes plus active-low cathodes) and recovers the hex digit shown on each display position.
- Provides the reverse path to the hex-to-cathode encoder, for on-board loopback self-check and for bench scoreboarding of display output.
- Each anode/cathode combination must hold for a programmable number of cycles before it is committed, so multiplexing transitions and glitches are rejected.

Parameters:
- NUM_DIGITS, 4, number of anode lines and digit slots.
- STABLE_CYCLES, 4, consecutive identical samples required before commit; legal range 1..255.
- CNT_W, 8, width of the stability counter; must hold STABLE_CYCLES.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- an  input  NUM_DIGITS  anode drive, active-low; bit k selects digit k.
- cathode  input  8  [0:7] = a,b,c,d,e,f,g,dp, all active-low.
- clear  input  1  synchronous clear of digit_valid and err_sticky.
- digits  output  4*NUM_DIGITS  digit k held in bits [4k+3:4k].
- digit_valid  output  NUM_DIGITS  slot k has been committed at least once since reset or clear.
- dp  output  NUM_DIGITS  decimal point lit for slot k, i.e. committed ~cathode[7].
- update  output  1  one-cycle pulse on each legal commit.
- upd_idx  output  $clog2(NUM_DIGITS)  slot written by the current update.
- err  output  1  one-cycle pulse on an illegal commit.
- err_sticky  output  1  set by err; cleared by reset or clear.

Behaviour:
- Reset: all outputs are 0. The sample register is 0 and cnt is 0.
- Sampling: the sample register s_q captures {an, cathode} on every edge.
  - If the new sample differs from s_q, cnt loads 1.
  - Otherwise cnt increments, saturating at STABLE_CYCLES.
- States:
  - TRACK (cnt < STABLE_CYCLES): no commit.
  - HELD (cnt == STABLE_CYCLES): exactly one commit occurs, on the edge after cnt first reaches STABLE_CYCLES. Nothing further is committed until the sample changes.
- Latency: let the first capture edge of a new value be E0 and the value stay unchanged through edge E0+STABLE_CYCLES-1. Then digits, digit_valid and update change at edge E0+STABLE_CYCLES. If any sample in that window differs, the count restarts from that sample.
- Commit decode:
  - an all ones (blanking): no action, no err.
  - an with more than one bit low: err pulse, err_sticky set, no digit change.
  - an with exactly one bit low (index k): match cathode[0:6], dp excluded, against the code table below.
    - Match: digits[k] gets the nibble, dp[k] gets ~cathode[7], digit_valid[k] is set, update=1, upd_idx=k.
    - No match: err pulse, err_sticky set, slot k unchanged.
- Code table, full 8-bit value with dp off:
  - 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F
  - 8=01, 9=09, A=05, b=C1, C=63, d=85, E=21, F=71
  - The decoder compares the upper 7 bits only.
- clear:
  - Clears digit_valid and err_sticky. digits and dp are retained.
  - If a commit falls in the same cycle, clear wins: the commit is dropped, update and err stay 0, and cnt stays saturated, so no retry happens.
- Reset mid-operation: the state returns to reset values immediately. The next commit requires a full STABLE_CYCLES window.
- update and err are never both high in the same cycle.

Decomposition:
- Shared package seg_pkg holds:
  - the 16-entry code constant array, shared with the encoder;
  - SEG_BLANK = 8'hFF;
  - a function seg_decode returning {hit, nibble}.
- One natural sub-module, seg_stable_det: the sample register plus stability counter, producing a one-cycle commit strobe and the held sample.

Test Plan:
- Apply an=4'b1110, cathode=8'h25, held 4 edges -> at edge 4: update=1, upd_idx=0, digits[3:0]=2, digit_valid=4'b0001, dp=0. Hold 10 more edges -> no further update.
- Hold an=4'b1011, cathode=8'hC0 (b, dp lit) for 4 edges -> digits[11:8]=4'hB, dp[2]=1, upd_idx=2. Toggle cathode to 8'h03 at sample 3 -> no commit until 4 fresh samples of 8'h03, then digits[11:8]=0.
- Cycle an through 1110/1101/1011/0111 with 2-cycle blank (an=1111, cathode=FF) gaps and patterns for 1,2,3,4, each held 6 cycles -> digits=16'h4321, digit_valid=4'hF, err never set.
- Hold cathode=8'hFE with an=4'b1101 for 4 edges -> err pulse, err_sticky=1, digits[7:4] unchanged. Hold an=4'b1100 with a legal pattern -> err again.
- Assert clear on the same edge a commit would occur -> update=0, digit_valid=0, err_sticky=0, digits retained.
- Deassert rst_n asynchronously mid-window (cnt=2) -> all outputs 0 at once. After release, a commit requires 4 full stable samples.
